tile_collision_checker: RTL and testbench

- Read-side consumer of the 30x40 tile map: a sprite-motion block proposes a pixel position, and this block scans every tile the sprite's bounding box would cover, one tile per clock.
- Reports whether any covered tile is a wall (bit = 1), plus the first wall hit.
- Sits between the tile map source and the player/enemy motion logic, so walls are enforced in hardware.

---
 rtl/tile_collision_checker.sv | 150 +++++++++++++++
 tb/tb_tile_collision_checker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tile_collision_checker.sv
// Tile-map collision scanner: walks every tile under a sprite's bounding box
// one tile per clock and reports the first wall hit or an off-screen box.
module tile_collision_checker #(
  parameter int SPRITE_W   = 16,
  parameter int SPRITE_H   = 16,
  parameter int TILE_SHIFT = 4,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [0:(SCREEN_H>>TILE_SHIFT)-1]
               [0:(SCREEN_W>>TILE_SHIFT)-1] Tile,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [9:0] req_x,
  input  logic [9:0] req_y,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_blocked,
  output logic       resp_oob,
  output logic [4:0] resp_row,
  output logic [5:0] resp_col,
  output logic [6:0] resp_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [10:0] x0, y0, x1, y1;
  logic        oob, accept, wall, last;

  logic [4:0] row_q, row_d, row_hi_q, row_hi_d;
  logic [5:0] col_q, col_d, col_lo_q, col_lo_d;
  logic [5:0] col_hi_q, col_hi_d;
  logic       blk_q, blk_d, oob_q, oob_d;
  logic [4:0] hrow_q, hrow_d;
  logic [5:0] hcol_q, hcol_d;
  logic [6:0] cnt_q, cnt_d;

  // 11-bit sums so a box hanging past the screen edge never wraps
  assign x0 = {1'b0, req_x};
  assign y0 = {1'b0, req_y};
  assign x1 = x0 + 11'(SPRITE_W - 1);
  assign y1 = y0 + 11'(SPRITE_H - 1);

  assign oob = (x0 + 11'(SPRITE_W) > 11'(SCREEN_W))
            || (y0 + 11'(SPRITE_H) > 11'(SCREEN_H));

  assign accept = req_valid && (state_q == IDLE);
  assign wall   = Tile[row_q][col_q];
  assign last   = (row_q == row_hi_q) && (col_q == col_hi_q);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid) state_d = oob ? DONE : SCAN;
      SCAN: if (wall || last) state_d = DONE;
      DONE: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == DONE);
  end

  always_comb begin
    row_d    = row_q;
    col_d    = col_q;
    col_lo_d = col_lo_q;
    row_hi_d = row_hi_q;
    col_hi_d = col_hi_q;
    blk_d    = blk_q;
    oob_d    = oob_q;
    hrow_d   = hrow_q;
    hcol_d   = hcol_q;
    cnt_d    = cnt_q;
    if (accept) begin
      row_d    = 5'(y0 >> TILE_SHIFT);
      col_d    = 6'(x0 >> TILE_SHIFT);
      col_lo_d = 6'(x0 >> TILE_SHIFT);
      row_hi_d = 5'(y1 >> TILE_SHIFT);
      col_hi_d = 6'(x1 >> TILE_SHIFT);
      blk_d    = oob;
      oob_d    = oob;
      hrow_d   = '0;
      hcol_d   = '0;
      cnt_d    = '0;
    end else if (state_q == SCAN) begin
      cnt_d = cnt_q + 7'd1;
      if (wall) begin
        blk_d  = 1'b1;
        hrow_d = row_q;
        hcol_d = col_q;
      end else if (!last) begin
        if (col_q == col_hi_q) begin
          col_d = col_lo_q;
          row_d = row_q + 5'd1;
        end else begin
          col_d = col_q + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      row_q    <= '0;
      col_q    <= '0;
      col_lo_q <= '0;
      row_hi_q <= '0;
      col_hi_q <= '0;
      blk_q    <= 1'b0;
      oob_q    <= 1'b0;
      hrow_q   <= '0;
      hcol_q   <= '0;
      cnt_q    <= '0;
    end else begin
      row_q    <= row_d;
      col_q    <= col_d;
      col_lo_q <= col_lo_d;
      row_hi_q <= row_hi_d;
      col_hi_q <= col_hi_d;
      blk_q    <= blk_d;
      oob_q    <= oob_d;
      hrow_q   <= hrow_d;
      hcol_q   <= hcol_d;
      cnt_q    <= cnt_d;
    end
  end

  assign resp_blocked = blk_q;
  assign resp_oob     = oob_q;
  assign resp_row     = hrow_q;
  assign resp_col     = hcol_q;
  assign resp_count   = cnt_q;

endmodule

// File: tb/tb_tile_collision_checker.sv
// Bench for tile_collision_checker: directed plan steps plus random requests
// on random maps, checked against a tile-walking reference model.
module tb_tile_collision_checker;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic [0:29][0:39] map;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [9:0]       req_x = '0;
  logic [9:0]       req_y = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic             resp_blocked;
  logic             resp_oob;
  logic [4:0]       resp_row;
  logic [5:0]       resp_col;
  logic [6:0]       resp_count;

  int passed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  tile_collision_checker dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Tile         (map),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_x        (req_x),
    .req_y        (req_y),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_blocked (resp_blocked),
    .resp_oob     (resp_oob),
    .resp_row     (resp_row),
    .resp_col     (resp_col),
    .resp_count   (resp_count)
  );

  typedef struct {
    int oob;
    int blk;
    int row;
    int col;
    int cnt;
  } res_t;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference: plain pixel arithmetic, then a row-major walk of the box
  function automatic res_t model(input int x, input int y);
    res_t r;
    r = '{0, 0, 0, 0, 0};
    if (x + 16 > 640 || y + 16 > 480) begin
      r.oob = 1;
      r.blk = 1;
      return r;
    end
    for (int rr = y / 16; rr <= (y + 15) / 16; rr++)
      for (int cc = x / 16; cc <= (x + 15) / 16; cc++) begin
        r.cnt++;
        if (map[rr][cc]) begin
          r.blk = 1;
          r.row = rr;
          r.col = cc;
          return r;
        end
      end
    return r;
  endfunction

  task automatic check_resp(input string tag, input res_t e);
    check({tag, "_valid"}, int'(resp_valid), 1);
    check({tag, "_blocked"}, int'(resp_blocked), e.blk);
    check({tag, "_oob"}, int'(resp_oob), e.oob);
    check({tag, "_row"}, int'(resp_row), e.row);
    check({tag, "_col"}, int'(resp_col), e.col);
    check({tag, "_count"}, int'(resp_count), e.cnt);
  endtask

  // Issue one request, time the response, hold it, then release it
  task automatic do_req(input string tag, input int x, input int y,
                        input int hold);
    res_t e;
    int   n;
    e = model(x, y);
    @(negedge Clk);
    check({tag, "_req_ready"}, int'(req_ready), 1);
    check({tag, "_idle_valid"}, int'(resp_valid), 0);
    req_valid = 1'b1;
    req_x     = 10'(x);
    req_y     = 10'(y);
    @(posedge Clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      if (!resp_valid && n > 1)
        check({tag, "_busy_ready"}, int'(req_ready), 0);
    end while (!resp_valid && n < 200);
    check({tag, "_latency"}, n, 1 + e.cnt);
    check_resp(tag, e);
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      check_resp({tag, "_hold"}, e);
      check({tag, "_hold_ready"}, int'(req_ready), 0);
    end
    resp_ready = 1'b1;
    @(posedge Clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    res_t z;
    int   x, y;
    z   = '{0, 0, 0, 0, 0};
    map = '0;
    map[1] = 40'h80_0000_0001;
    map[2] = 40'h80_0000_0001;
    map[4] = 40'h81_FF00_0001;

    repeat (2) @(negedge Clk);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_count", int'(resp_count), 0);
    Reset = 1'b0;

    // Reset while the 4-tile scan is in flight
    @(negedge Clk);
    req_valid = 1'b1;
    req_x = 10'd40;
    req_y = 10'd24;
    @(posedge Clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    check("midrst_req_ready", int'(req_ready), 1);
    check("midrst_valid", int'(resp_valid), 0);
    check("midrst_blocked", int'(resp_blocked), 0);
    check("midrst_oob", int'(resp_oob), 0);
    check("midrst_row", int'(resp_row), 0);
    check("midrst_col", int'(resp_col), 0);
    check("midrst_count", int'(resp_count), 0);
    @(negedge Clk);
    Reset = 1'b0;

    do_req("fresh", 40, 24, 0);
    do_req("aligned", 32, 16, 0);
    do_req("quad_hold", 40, 24, 5);
    do_req("b2b_wall", 100, 64, 0);
    do_req("oob_x", 630, 0, 0);
    do_req("corner", 624, 464, 0);
    do_req("oob_y", 0, 470, 2);
    do_req("col0_wall", 0, 16, 0);

    // Cross-check a few plan numbers against fixed expectations too
    z = model(100, 64);
    check("plan_wall_cnt", z.cnt, 2);
    check("plan_wall_col", z.col, 7);

    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < 30; r++)
        for (int c = 0; c < 40; c++)
          map[r][c] = ($urandom_range(0, 7) == 0);
      x = (t % 5 == 0) ? $urandom_range(600, 700) : $urandom_range(0, 624);
      y = (t % 7 == 0) ? $urandom_range(450, 520) : $urandom_range(0, 464);
      do_req("rand", x, y, t % 3);
    end

    @(negedge Clk);
    check("end_req_ready", int'(req_ready), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
